// File: rtl/flash_read_controller.sv
// flash_read_controller: SPI mode-0 serial flash reader (command, 24-bit address, dummy bytes, byte-wise read)
// Ports: clk_in/reset_in clock and sync reset; FLASH_enable holds a session open; FLASH_data_out/flash_addr
// command and start address latched at session start; FLASH_continue_read requests the next byte;
// FLASH_data_in last byte read, valid while FLASH_busy=0; spi_cs_n/spi_sck/spi_mosi/spi_miso flash pins.
module flash_read_controller #(
  parameter int CLK_DIV     = 2,
  parameter int DUMMY_BYTES = 0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        FLASH_enable,
  input  logic [7:0]  FLASH_data_out,
  input  logic [23:0] flash_addr,
  input  logic        FLASH_continue_read,
  output logic [7:0]  FLASH_data_in,
  output logic        FLASH_busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] DUMMY = 3'd3;
  localparam logic [2:0] READ  = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;
  localparam logic [2:0] STOP  = 3'd6;
  localparam logic [8:0] DIV_LD  = 9'(CLK_DIV - 1);
  localparam logic [8:0] STOP_LD = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] LAST_PRE = 4'(DUMMY_BYTES + 2);
  logic [2:0]  state;
  logic [8:0]  div;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic [23:0] addr;
  // mosi comes straight from the transmit register's MSB, so it stays a registered output
  assign spi_mosi = tx[7];
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      spi_cs_n      <= 1'b1;
      spi_sck       <= 1'b0;
      tx            <= 8'h00;
      rx            <= 8'h00;
      addr          <= 24'h0;
      FLASH_busy    <= 1'b1;
      FLASH_data_in <= 8'h00;
      div           <= 9'd0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= 4'd0;
    end else if (state == IDLE) begin
      if (FLASH_enable) begin
        state    <= CMD;
        spi_cs_n <= 1'b0;
        tx       <= FLASH_data_out;
        addr     <= flash_addr;
        div      <= DIV_LD;
        bit_cnt  <= 3'd7;
        byte_cnt <= 4'd0;
      end
    end else if (state == STOP) begin
      if (div == 9'd0) state <= IDLE;
      else div <= div - 1'b1;
    end else if (!FLASH_enable) begin
      // abort beats everything else, including a simultaneous continue pulse
      state      <= STOP;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      FLASH_busy <= 1'b1;
      tx         <= 8'h00;
      div        <= STOP_LD;
    end else if (state == WAIT) begin
      if (FLASH_continue_read) begin
        state      <= READ;
        FLASH_busy <= 1'b1;
        div        <= DIV_LD;
        bit_cnt    <= 3'd7;
      end
    end else if (div != 9'd0) begin
      div <= div - 1'b1;
    end else begin
      div     <= DIV_LD;
      spi_sck <= !spi_sck;
      if (!spi_sck) begin
        // miso is taken on the cycle the rising edge is launched
        if (state == READ) rx <= {rx[6:0], spi_miso};
      end else if (bit_cnt != 3'd0) begin
        bit_cnt <= bit_cnt - 1'b1;
        tx      <= {tx[6:0], 1'b0};
      end else begin
        bit_cnt <= 3'd7;
        if (state == CMD || (state == ADDR && byte_cnt != 4'd2)) begin
          state    <= ADDR;
          tx       <= addr[23:16];
          addr     <= {addr[15:0], 8'h00};
          byte_cnt <= (state == CMD) ? 4'd0 : byte_cnt + 1'b1;
        end else if (state == ADDR || state == DUMMY) begin
          // byte_cnt keeps running through the dummy bytes after the three address bytes
          tx       <= 8'h00;
          byte_cnt <= byte_cnt + 1'b1;
          state    <= (byte_cnt == LAST_PRE) ? READ : DUMMY;
        end else begin
          state         <= WAIT;
          FLASH_data_in <= rx;
          FLASH_busy    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_flash_read_controller.sv
// tb_flash_read_controller: directed self-checking bench for flash_read_controller
module tb_flash_read_controller;
  logic        clk_in = 1'b0;
  logic        reset_in, en, cont;
  logic [7:0]  cmd, mb;
  logic [23:0] addr;
  logic [1:0]  cs_n, sck, mosi, miso, busy;
  logic [7:0]  din0, din1;
  logic [6:0]  edges [2] = '{7'd0, 7'd0};
  logic [1:0]  sck_q = 2'b00;
  logic [7:0]  msr [2] = '{8'h00, 8'h00};
  logic [7:0]  blog [2][16];
  int          rises [2] = '{0, 0};
  int          checks = 0, errors = 0;
  int          n, r0;

  always #5 clk_in = ~clk_in;

  flash_read_controller #(.CLK_DIV(2), .DUMMY_BYTES(0)) dut0 (
    .clk_in(clk_in), .reset_in(reset_in), .FLASH_enable(en), .FLASH_data_out(cmd),
    .flash_addr(addr), .FLASH_continue_read(cont), .FLASH_data_in(din0), .FLASH_busy(busy[0]),
    .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

  flash_read_controller #(.CLK_DIV(2), .DUMMY_BYTES(1)) dut1 (
    .clk_in(clk_in), .reset_in(reset_in), .FLASH_enable(en), .FLASH_data_out(cmd),
    .flash_addr(addr), .FLASH_continue_read(cont), .FLASH_data_in(din1), .FLASH_busy(busy[1]),
    .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

  // flash model: one bit per SCK rising edge, MSB first, byte-aligned to the session start
  assign miso[0] = mb[~edges[0][2:0]];
  assign miso[1] = mb[~edges[1][2:0]];

  always @(posedge clk_in)
    for (int g = 0; g < 2; g++) begin
      sck_q[g] <= sck[g];
      if (sck[g] && !sck_q[g]) begin
        rises[g] <= rises[g] + 1;
        msr[g]   <= {msr[g][6:0], mosi[g]};
        if (edges[g][2:0] == 3'd7) blog[g][edges[g][6:3]] <= {msr[g][6:0], mosi[g]};
      end
      edges[g] <= cs_n[g] ? 7'd0 : edges[g] + 7'(sck[g] && !sck_q[g]);
    end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input int g, output int cnt);
    cnt = 0;
    while (busy[g] && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset_in = 1'b1; en = 1'b0; cont = 1'b0; cmd = 8'h03; addr = 24'h123456; mb = 8'hA5;
    repeat (3) tick();
    check("rst_cs", 32'(cs_n[0]), 1);
    check("rst_sck", 32'(sck[0]), 0);
    check("rst_mosi", 32'(mosi[0]), 0);
    check("rst_busy", 32'(busy[0]), 1);
    check("rst_din", 32'(din0), 0);
    reset_in = 1'b0;
    tick();
    check("idle_cs", 32'(cs_n[0]), 1);
    en = 1'b1;
    tick();
    check("cs_fall", 32'(cs_n[0]), 0);
    check("cmd_b7", 32'(mosi[0]), 0);
    wait_busy(0, n);
    check("busy_fall_first", n, 160);
    check("din_a5", 32'(din0), 32'hA5);
    check("mosi_cmd", 32'(blog[0][0]), 32'h03);
    check("mosi_a2", 32'(blog[0][1]), 32'h12);
    check("mosi_a1", 32'(blog[0][2]), 32'h34);
    check("mosi_a0", 32'(blog[0][3]), 32'h56);
    check("edges_first", 32'(edges[0]), 40);
    r0 = rises[0]; mb = 8'h5A;
    cont = 1'b1;
    tick();
    cont = 1'b0;
    check("busy_rise", 32'(busy[0]), 1);
    repeat (5) tick();
    cont = 1'b1;
    tick();
    cont = 1'b0;
    wait_busy(0, n);
    check("busy_fall_next", n, 26);
    check("din_5a", 32'(din0), 32'h5A);
    check("rises_next", rises[0] - r0, 8);
    repeat (40) tick();
    check("no_queued_busy", 32'(busy[0]), 0);
    check("no_queued_rises", rises[0] - r0, 8);
    r0 = rises[0];
    en = 1'b0; cont = 1'b1;
    tick();
    cont = 1'b0;
    check("abw_cs", 32'(cs_n[0]), 1);
    check("abw_sck", 32'(sck[0]), 0);
    check("abw_busy", 32'(busy[0]), 1);
    repeat (10) tick();
    check("abw_rises", rises[0] - r0, 0);
    check("abw_din", 32'(din0), 32'h5A);
    mb = 8'hA5; en = 1'b1;
    n = 0;
    while (edges[0] != 7'd20 && n < 400) begin
      tick();
      n++;
    end
    check("reach_addr_bit3", 32'(edges[0]), 20);
    en = 1'b0;
    tick();
    check("ab_cs", 32'(cs_n[0]), 1);
    check("ab_sck", 32'(sck[0]), 0);
    check("ab_busy", 32'(busy[0]), 1);
    check("ab_din", 32'(din0), 32'h5A);
    en = 1'b1;
    n = 0;
    while (cs_n[0] && n < 50) begin
      n++;
      tick();
    end
    check("cs_high_stop_idle", n, 5);
    wait_busy(0, n);
    check("busy_fall_restart", n, 160);
    check("din_restart", 32'(din0), 32'hA5);
    mb = 8'h5A;
    cont = 1'b1;
    tick();
    cont = 1'b0;
    repeat (10) tick();
    reset_in = 1'b1; en = 1'b0;
    tick();
    check("mrst_cs", 32'(cs_n[0]), 1);
    check("mrst_sck", 32'(sck[0]), 0);
    check("mrst_busy", 32'(busy[0]), 1);
    check("mrst_din", 32'(din0), 0);
    reset_in = 1'b0;
    r0 = rises[0];
    tick();
    cont = 1'b1;
    tick();
    cont = 1'b0;
    repeat (20) tick();
    check("idle_cont_rises", rises[0] - r0, 0);
    check("idle_cont_cs", 32'(cs_n[0]), 1);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0; cmd = 8'h0B; mb = 8'hC3; en = 1'b1;
    tick();
    check("post_rst_cs", 32'(cs_n[1]), 0);
    wait_busy(1, n);
    check("busy_fall_dummy", n, 192);
    check("dmy_cmd", 32'(blog[1][0]), 32'h0B);
    check("dmy_a0", 32'(blog[1][3]), 32'h56);
    check("dmy_byte5", 32'(blog[1][4]), 32'h00);
    check("dmy_din", 32'(din1), 32'hC3);
    check("nodmy_din", 32'(din0), 32'hC3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
